output_deserializer: RTL and testbench

//  Collects a serial stream of neuron results, one dataWidth word per accepted beat, into a

---
 rtl/nn_pkg.sv | 16 +
 rtl/output_deserializer.sv | 148 ++++++++++++++
 tb/tb_output_deserializer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/nn_pkg.sv
// Shared neural-network datapath definitions: deserializer state encoding and
// word-slice addressing helper.
package nn_pkg;

    typedef enum logic [0:0] {
        DESER_COLLECT = 1'b0,
        DESER_FULL    = 1'b1
    } deser_state_t;

    // LSB position of word idx in a packed vector of dataWidth-bit words.
    function automatic int unsigned slice_lsb(input int unsigned idx,
                                              input int unsigned dataWidth);
        return idx * dataWidth;
    endfunction

endpackage

// File: rtl/output_deserializer.sv
// Gathers a serial stream of dataWidth words into a packed frame, word 0 at the LSB.
// Optional sticky overrun flag on writes into a held frame: DESER_OVERRUN_FLAG_EN.
//
// state         | meaning
// DESER_COLLECT | accepting words into slot countOut, serialReady=1
// DESER_FULL    | frame complete and held; serialReady follows parallelReady
module output_deserializer
    import nn_pkg::*;
#(
    parameter int numOutputs   = 16,
    parameter int dataWidth    = 8,
    parameter int counterWidth = $clog2(numOutputs + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic [dataWidth-1:0]            serialIn,
    input  logic                            serialValid,
    output logic                            serialReady,
    output logic [dataWidth*numOutputs-1:0] parallelOut,
    output logic                            parallelValid,
    input  logic                            parallelReady,
    output logic [counterWidth-1:0]         countOut
`ifdef DESER_OVERRUN_FLAG_EN
    ,
    output logic                            overrun
`endif
);

    localparam logic [counterWidth-1:0] LAST_IDX = counterWidth'(numOutputs - 1);

    deser_state_t                    r_state;
    deser_state_t                    w_state_nxt;
    logic [counterWidth-1:0]         r_count;
    logic [counterWidth-1:0]         w_count_nxt;
    logic                            r_valid;
    logic                            w_valid_nxt;
    logic [dataWidth*numOutputs-1:0] r_data;
    logic                            w_accept;
    logic [counterWidth-1:0]         w_wr_idx;
    logic [numOutputs-1:0]           w_slot_we;

    assign serialReady = (r_state == DESER_COLLECT) ? 1'b1 : parallelReady;

    // flush drops any word offered in the same cycle
    assign w_accept = serialValid && serialReady && !flush;

    // a zero-bubble accept out of FULL always restarts at slot 0
    assign w_wr_idx = (r_state == DESER_FULL) ? '0 : r_count;

    for (genvar k = 0; k < numOutputs; k++) begin : g_slot_we
        assign w_slot_we[k] = w_accept && (w_wr_idx == counterWidth'(k));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= DESER_COLLECT;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_valid_nxt = r_valid;
        if (flush) begin
            w_state_nxt = DESER_COLLECT;
            w_count_nxt = '0;
            w_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                DESER_COLLECT: begin
                    if (w_accept) begin
                        if (r_count == LAST_IDX) begin
                            w_state_nxt = DESER_FULL;
                            w_count_nxt = '0;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_count_nxt = r_count + counterWidth'(1);
                        end
                    end
                end
                DESER_FULL: begin
                    if (parallelReady) begin
                        if (w_accept && (numOutputs == 1)) begin
                            // single-word frames complete on the very word that frees the hold
                            w_state_nxt = DESER_FULL;
                            w_count_nxt = '0;
                            w_valid_nxt = 1'b1;
                        end else if (w_accept) begin
                            w_state_nxt = DESER_COLLECT;
                            w_count_nxt = counterWidth'(1);
                            w_valid_nxt = 1'b0;
                        end else begin
                            w_state_nxt = DESER_COLLECT;
                            w_valid_nxt = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state_nxt = DESER_COLLECT;
                    w_count_nxt = '0;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= '0;
        end else if (flush) begin
            r_data <= '0;
        end else begin
            for (int unsigned k = 0; k < numOutputs; k++) begin
                if (w_slot_we[k]) begin
                    r_data[slice_lsb(k, dataWidth) +: dataWidth] <= serialIn;
                end
            end
        end
    end

    assign parallelOut   = r_data;
    assign parallelValid = r_valid;
    assign countOut      = r_count;

`ifdef DESER_OVERRUN_FLAG_EN
    logic r_overrun;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overrun <= 1'b0;
        end else if (flush) begin
            r_overrun <= 1'b0;
        end else if (serialValid && !serialReady) begin
            r_overrun <= 1'b1;
        end
    end

    assign overrun = r_overrun;
`endif

endmodule

// File: tb/tb_output_deserializer.sv
// Randomized scoreboard bench for output_deserializer (numOutputs=4, dataWidth=8);
// overrun checks are active when DESER_OVERRUN_FLAG_EN is defined.
module tb_output_deserializer;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int CW = $clog2(N + 1);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           flush;
    logic [W-1:0]   serialIn;
    logic           serialValid;
    logic           serialReady;
    logic [W*N-1:0] parallelOut;
    logic           parallelValid;
    logic           parallelReady;
    logic [CW-1:0]  countOut;
`ifdef DESER_OVERRUN_FLAG_EN
    logic           overrun;
`endif

    int vectors     = 0;
    int miscompares = 0;

    output_deserializer #(.numOutputs(N), .dataWidth(W)) dut (
        .clk           (clk),
        .reset         (rst_n),
        .flush         (flush),
        .serialIn      (serialIn),
        .serialValid   (serialValid),
        .serialReady   (serialReady),
        .parallelOut   (parallelOut),
        .parallelValid (parallelValid),
        .parallelReady (parallelReady),
        .countOut      (countOut)
`ifdef DESER_OVERRUN_FLAG_EN
        ,
        .overrun       (overrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a word queue for the partial frame plus a "frame held" flag.
    logic [W*N-1:0] sb[$];
    logic [W-1:0]   m_words[$];
    bit             m_full;
    bit             m_ovr;

    function automatic logic [W*N-1:0] pack_words(input logic [W-1:0] ws[$]);
        logic [W*N-1:0] f = '0;
        for (int i = 0; i < ws.size(); i++) f[i*W +: W] = ws[i];
        return f;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit rdy;
        if (!rst_n) begin
            m_words.delete();
            sb.delete();
            m_full = 1'b0;
            m_ovr  = 1'b0;
        end else begin
            rdy = !m_full || parallelReady;
            if (flush) begin
                if (m_full) void'(sb.pop_back());
                m_words.delete();
                m_full = 1'b0;
                m_ovr  = 1'b0;
            end else begin
                if (serialValid && !rdy) m_ovr = 1'b1;
                if (m_full && parallelReady) m_full = 1'b0;
                if (serialValid && rdy) begin
                    m_words.push_back(serialIn);
                    if (m_words.size() == N) begin
                        sb.push_back(pack_words(m_words));
                        m_words.delete();
                        m_full = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("serialReady", 64'(serialReady), 64'(!m_full || parallelReady));
            chk("countOut", 64'(countOut), 64'(m_words.size()));
            chk("parallelValid", 64'(parallelValid), 64'(m_full));
`ifdef DESER_OVERRUN_FLAG_EN
            chk("overrun", 64'(overrun), 64'(m_ovr));
`endif
            if (m_full) begin
                if (sb.size() == 0) begin
                    chk("scoreboard_empty", 64'(sb.size()), 64'd1);
                end else begin
                    chk("frame", 64'(parallelOut), 64'(sb[0]));
                    if (parallelReady && !flush) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step(input bit v, input logic [W-1:0] d, input bit pr, input bit fl);
        serialValid   = v;
        serialIn      = d;
        parallelReady = pr;
        flush         = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit pr);
        serialValid   = 1'b0;
        serialIn      = '0;
        parallelReady = pr;
        flush         = 1'b0;
    endtask

    initial begin
        logic [W-1:0]   w;
        logic [W*N-1:0] exp_f;

        rst_n = 1'b0;
        idle(1'b0);
        #1;
        chk("reset_countOut", 64'(countOut), 64'd0);
        chk("reset_parallelValid", 64'(parallelValid), 64'd0);
        chk("reset_parallelOut", 64'(parallelOut), 64'd0);
        chk("reset_serialReady", 64'(serialReady), 64'd1);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // async reset mid-cycle while a full frame is held
        for (int i = 0; i < N; i++) step(1'b1, W'($urandom), 1'b0, 1'b0);
        idle(1'b0);
        chk("t1_loaded", 64'(parallelValid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_countOut", 64'(countOut), 64'd0);
        chk("t1_parallelValid", 64'(parallelValid), 64'd0);
        chk("t1_parallelOut", 64'(parallelOut), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back frame with downstream stalled
        step(1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 8'h44, 1'b0, 1'b0);
        idle(1'b0);
        chk("t2_parallelValid", 64'(parallelValid), 64'd1);
        chk("t2_parallelOut", 64'(parallelOut), 64'h44332211);
        chk("t2_serialReady", 64'(serialReady), 64'd0);

        // hold FULL while upstream keeps pushing
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h99, 1'b0, 1'b0);
            chk("t3_hold_out", 64'(parallelOut), 64'h44332211);
            chk("t3_hold_count", 64'(countOut), 64'd0);
`ifdef DESER_OVERRUN_FLAG_EN
            chk("t3_overrun", 64'(overrun), 64'd1);
`endif
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(1'b0);
        chk("t3_flush_valid", 64'(parallelValid), 64'd0);
        chk("t3_flush_out", 64'(parallelOut), 64'd0);

        // continuous stream with downstream always ready
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, W'(i), 1'b1, 1'b0);
            if (i == 4) chk("t4_frame0", 64'(parallelOut), 64'h04030201);
            if (i == 8) chk("t4_frame1", 64'(parallelOut), 64'h08070605);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // flush drops the coincident word
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0);
        chk("t5_count_before", 64'(countOut), 64'd2);
        step(1'b1, 8'hCC, 1'b0, 1'b1);
        chk("t5_count_after", 64'(countOut), 64'd0);
        exp_f = '0;
        for (int i = 0; i < N; i++) begin
            w = W'($urandom);
            exp_f[i*W +: W] = w;
            step(1'b1, w, 1'b0, 1'b0);
        end
        idle(1'b0);
        chk("t5_frame", 64'(parallelOut), 64'(exp_f));
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // reset in the middle of a frame
        for (int i = 0; i < 3; i++) step(1'b1, 8'hE0 + W'(i), 1'b0, 1'b0);
        idle(1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_count_reset", 64'(countOut), 64'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_f = '0;
        for (int i = 0; i < N; i++) begin
            w = W'($urandom);
            exp_f[i*W +: W] = w;
            step(1'b1, w, 1'b0, 1'b0);
        end
        idle(1'b0);
        chk("t6_frame", 64'(parallelOut), 64'(exp_f));
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // randomized traffic, checked by the monitor
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(99) < 70, W'($urandom), $urandom_range(99) < 50,
                 $urandom_range(99) < 3);
        end
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain_scoreboard", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
